// File: rtl/tt_top_pkg.sv
// Shared constants for the seven-segment seconds counter tile.
package tt_top_pkg;

   // Default prescaler period in clock cycles per tick (10 MHz tile clock)
   localparam int unsigned CLK_HZ_DEFAULT = 10_000_000;

   // Width of the prescaler counter and of the compare value
   localparam int unsigned CNT_W = 24;

   // Digit width and the last digit value before wrapping to zero
   localparam int unsigned DIGIT_W   = 4;
   localparam logic [3:0]  DIGIT_MAX = 4'd9;

   // Segment patterns, bit 0 = a ... bit 6 = g, active-high
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_NONE = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to seven-segment pattern decoder.
module seg7_decoder
   import tt_top_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [6:0]         seg_o
);

   // Map each decimal digit to its lit segments; non-decimal codes stay dark
   always_comb begin
      seg_o = SEG_NONE;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_NONE;
      endcase
   end

endmodule

// File: rtl/tt_um_top_module.sv
// TinyTapeout top: prescaled one-second tick driving a 0-9 digit on a
// seven-segment display. Reset pin is named rst_n by the harness but is
// active-high and asynchronous.
module tt_um_top_module
   import tt_top_pkg::*;
#(
   parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [CNT_W-1:0] DEFAULT_CMP = CNT_W'(CLK_HZ);

   logic                 override;
   logic [CNT_W-1:0]     compare_raw;
   logic [CNT_W-1:0]     compare;
   logic [CNT_W-1:0]     limit;
   logic                 tick;
   logic [CNT_W-1:0]     sec_cnt_q, sec_cnt_d;
   logic [DIGIT_W-1:0]   digit_q, digit_d;
   logic [6:0]           seg;
   logic                 unused_ok;

   assign override = ui_in[0];

   // Period selection; pins are quasi-static so they are used unsynchronised
   always_comb begin
      compare_raw = override ? {6'b0, uio_in, 10'b0} : DEFAULT_CMP;
      compare     = (compare_raw == '0) ? CNT_W'(1) : compare_raw;
      limit       = compare - CNT_W'(1);
   end

   // Greater-or-equal lets a shrinking period wrap immediately instead of
   // running the counter all the way round the 24-bit range
   always_comb begin
      tick      = ena && (sec_cnt_q >= limit);
      sec_cnt_d = sec_cnt_q;
      digit_d   = digit_q;
      if (tick) begin
         sec_cnt_d = '0;
         digit_d   = (digit_q >= DIGIT_MAX) ? '0 : digit_q + DIGIT_W'(1);
      end else if (ena) begin
         sec_cnt_d = sec_cnt_q + CNT_W'(1);
      end
   end

   // State registers with asynchronous active-high clear
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         sec_cnt_q <= '0;
         digit_q   <= '0;
      end else begin
         sec_cnt_q <= sec_cnt_d;
         digit_q   <= digit_d;
      end
   end

   seg7_decoder u_dec (
      .digit_i (digit_q),
      .seg_o   (seg)
   );

   assign uo_out  = {1'b0, seg};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

   // Remaining dedicated inputs have no function
   assign unused_ok = &{1'b0, ui_in[7:1]};

endmodule

// File: tb/tb_tt_um_top_module.sv
// Directed bench for the seven-segment seconds counter using the fast
// override period (1024 cycles per tick).
`timescale 1ns/1ps
module tb_tt_um_top_module;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks   = 0;
   int failures = 0;

   logic [7:0] seg_tbl [10];

   tt_um_top_module dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %02h", tag, got);
      end
   endtask

   // Advance n rising edges, then settle 1ns past the last edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      seg_tbl[0] = 8'h3F; seg_tbl[1] = 8'h06; seg_tbl[2] = 8'h5B;
      seg_tbl[3] = 8'h4F; seg_tbl[4] = 8'h66; seg_tbl[5] = 8'h6D;
      seg_tbl[6] = 8'h7D; seg_tbl[7] = 8'h07; seg_tbl[8] = 8'h7F;
      seg_tbl[9] = 8'h6F;

      rst_n  = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h01;
      uio_in = 8'h01;

      // Release between edges: posedges at 5,15,25...; first counted edge at 25
      #22;
      rst_n = 1'b0;
      #1;
      check("reset_uo",  uo_out,  8'h3F);
      check("reset_oe",  uio_oe,  8'h00);
      check("reset_out", uio_out, 8'h00);

      // Fast period: no tick one edge early, tick exactly on edge 1024
      step(1023);
      check("pre_tick_1023", uo_out, 8'h3F);
      step(1);
      check("tick_1024", uo_out, 8'h06);
      for (int d = 2; d <= 9; d++) begin
         step(1024);
         check($sformatf("digit_%0d", d), uo_out, seg_tbl[d]);
      end

      // Wrap 9 -> 0 -> 1
      step(1024);
      check("wrap_to_0", uo_out, 8'h3F);
      step(1024);
      check("after_wrap_1", uo_out, 8'h06);

      // Enable gating: 300 counted, hold 5000 cycles, then 724 more to tick
      step(300);
      ena = 1'b0;
      step(5000);
      check("ena_low_hold", uo_out, 8'h06);
      check("ena_low_bit7", {7'b0, uo_out[7]}, 8'h00);
      ena = 1'b1;
      step(723);
      check("ena_resume_pre", uo_out, 8'h06);
      step(1);
      check("ena_resume_tick", uo_out, 8'h5B);

      // Period shrink: at count 1500 of a 2048 period switch to 1024
      uio_in = 8'h02;
      step(1500);
      check("shrink_before", uo_out, 8'h5B);
      uio_in = 8'h01;
      step(1);
      check("shrink_immediate", uo_out, 8'h4F);
      step(1023);
      check("shrink_period_pre", uo_out, 8'h4F);
      step(1);
      check("shrink_period_tick", uo_out, 8'h66);

      // Advance to digit 7, then asynchronous reset between edges
      step(3 * 1024);
      check("at_digit_7", uo_out, 8'h07);
      step(100);
      #2;
      rst_n = 1'b1;
      #1;
      check("async_reset_now", uo_out, 8'h3F);
      #2;
      rst_n = 1'b0;
      step(1023);
      check("post_reset_pre", uo_out, 8'h3F);
      step(1);
      check("post_reset_tick", uo_out, 8'h06);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tt_um_top_module.md
# tt_um_top_module

Seven-segment seconds counter for the TinyTapeout tile. A 24-bit prescaler divides the tile clock down to a one-second tick (10 MHz clock by default, or a shorter period chosen through the pins). Each tick advances a decimal digit 0–9. The digit drives a seven-segment display on the dedicated outputs. The block is the top-level user module placed directly in the TinyTapeout harness.

## Interface
Parameters:
- `CLK_HZ`, default 10_000_000: default prescaler period, in cycles per tick.

Ports:
- `clk`, input, 1: the single clock. All state is clocked on its rising edge.
- `rst_n`, input, 1: reset. Asynchronous and active-high: a value of 1 resets the block. The name follows the harness convention, but the polarity is high.
- `ena`, input, 1: harness enable. While low, all state holds.
- `ui_in`, input, 8: dedicated inputs. Bit 0 is `override`. Bits 7:1 are unused.
- `uio_in`, input, 8: override period value, `P`.
- `uo_out`, output, 8: bits 6:0 are segments a..g, active-high, with bit 0 = a. Bit 7 is always 0.
- `uio_out`, output, 8: constant 8'h00.
- `uio_oe`, output, 8: constant 8'h00, so all bidirectional pins are inputs.

## Operation
- Period selection is combinational and sampled every cycle:
  - When `override` = 1: `compare` = {6'b0, `uio_in`, 10'b0}, a 24-bit value.
  - When `override` = 0: `compare` = `CLK_HZ`.
  - A `compare` of 0 is treated as 1.
- `sec_cnt`, 24 bits, unsigned:
  - When `ena` = 1 and `sec_cnt` >= `compare` − 1: `sec_cnt` goes to 0 and a tick is generated in that cycle.
  - Otherwise, when `ena` = 1: `sec_cnt` increments by 1.
  - The >= test gives immediate wrap when `compare` shrinks below the current count.
- `digit`, 4 bits: on each tick it increments, and 9 wraps to 0. Values 10–15 are unreachable.
- Segment decode, combinational from `digit`, giving `uo_out`[6:0]:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F
  - Any other value decodes to 00.
- `ena` = 0: `sec_cnt` and `digit` hold, and no tick is generated. The outputs keep showing the held digit.

## Timing
- Reset values: `sec_cnt` = 0 and `digit` = 0, so `uo_out` = 8'h3F, `uio_out` = 8'h00 and `uio_oe` = 8'h00.
  - Reset takes effect immediately, without waiting for a clock edge.
  - The first count happens on the first rising edge after deassertion.
- Constant period N, `ena` high: `digit` changes on the N-th, 2N-th, … rising edges after reset release.
- `uo_out` follows `digit` combinationally, with no extra latency.
- Period change mid-count: it takes effect on the next edge, with no glitch in `digit`.
  - At most one tick per cycle.
- Reset asserted mid-count: both registers clear at once. The next period starts from 0.
- `override` and `uio_in` are used unsynchronised. Pins are quasi-static by contract.

## Structure
- Shared package `tt_top_pkg`: `CLK_HZ` default, the 24-bit counter width, the `DIGIT_MAX` = 9 constant, and the segment pattern constants for 0–9.
- One sub-module, `seg7_decoder`: 4-bit digit in, 7-bit segments out, purely combinational.
- The top level holds the prescaler, the digit counter and the pin assignments.

## Test plan
- Reset: hold `rst_n` = 1, then release with `ena` = 1 and `ui_in` = 0. Required: `uo_out` = 8'h3F, `uio_oe` = 00, `uio_out` = 00.
- Fast period: `ui_in` = 01, `uio_in` = 01 (`compare` = 1024). Required: `uo_out` = 06 after 1024 edges, 5B after 2048, and the full sequence to 6F after 9216.
- Wrap: continue the fast-period case. Required: 3F after 10240 edges, then 06 again after 11264.
- Enable gating: drop `ena` for 5000 cycles mid-period. Required: `uo_out` unchanged. After re-enabling, the digit advances exactly (1024 − cycles already counted) edges later.
- Period shrink: at count 1500 with `uio_in` = 02, switch to `uio_in` = 01. Required: tick on the next edge, then the normal 1024-cycle period.
- Async reset mid-count: at digit 7, pulse `rst_n` high between clock edges. Required: `uo_out` = 3F immediately. The next tick comes a full period after release.
